// File: rtl/tlul_pkg.sv
// Shared TL-UL encodings, GPIO register offsets and the byte-lane merge helper
// used by the multi-channel GPIO slave.
package tlul_pkg;

  typedef enum logic [2:0] {
    PUT_FULL    = 3'd0,
    PUT_PARTIAL = 3'd1,
    GET         = 3'd4
  } a_op_e;

  typedef enum logic [2:0] {
    ACK      = 3'd0,
    ACK_DATA = 3'd1
  } d_op_e;

  typedef enum logic [1:0] {
    REG_OUT    = 2'd0,
    REG_IN     = 2'd1,
    REG_MODE   = 2'd2,
    REG_PERIOD = 2'd3
  } reg_e;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Replace only the byte lanes enabled in mask; callers truncate to register width.
  function automatic logic [31:0] lane_merge(input logic [31:0] old,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  mask);
    logic [31:0] res;
    for (int unsigned b = 0; b < 4; b++) begin
      res[8*b +: 8] = mask[b] ? wdata[8*b +: 8] : old[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/tlul_gpio_channel.sv
// One GPIO/LED channel: OUT/MODE/PERIOD registers, 2-flop input synchroniser,
// blink counter with phase, and output gating.
module tlul_gpio_channel
  import tlul_pkg::*;
#(
  parameter int unsigned LED_W = 8,
  parameter int unsigned CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [1:0]       wr_reg,
  input  logic [3:0]       wr_mask,
  input  logic [31:0]      wr_data,
  input  logic [LED_W-1:0] pins,
  output logic [LED_W-1:0] out_reg,
  output logic [LED_W-1:0] in_reg,
  output logic             blink_en,
  output logic [CNT_W-1:0] period,
  output logic [LED_W-1:0] led
);

  logic [LED_W-1:0] sync1;
  logic [CNT_W-1:0] cnt;
  logic             phase;
  logic             restart;
  logic             running;
  logic             wrap;

  assign restart = we && ((wr_reg == REG_MODE) || (wr_reg == REG_PERIOD));
  assign running = blink_en && (period != '0);
  assign wrap    = (cnt == period - CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_reg  <= '0;
      blink_en <= 1'b0;
      period   <= '0;
    end else if (we) begin
      case (wr_reg)
        REG_OUT:    out_reg  <= LED_W'(lane_merge(32'(out_reg), wr_data, wr_mask));
        REG_MODE:   blink_en <= 1'(lane_merge({31'b0, blink_en}, wr_data, wr_mask));
        REG_PERIOD: period   <= CNT_W'(lane_merge(32'(period), wr_data, wr_mask));
        default: ;
      endcase
    end
  end

  // A MODE/PERIOD write restarts the blink cycle and takes priority over a wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (restart) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (running) begin
      if (wrap) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= '0;
      in_reg <= '0;
    end else begin
      sync1  <= pins;
      in_reg <= sync1;
    end
  end

  assign led = blink_en ? (out_reg & {LED_W{phase}}) : out_reg;

endmodule

// File: rtl/tlul_slave_gpio.sv
// TL-UL slave exposing NUM_CH GPIO/LED channels; single outstanding request,
// response registered at acceptance and held until the D handshake.
module tlul_slave_gpio
  import tlul_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned LED_W  = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned SRC_W  = 4,
  parameter int unsigned CNT_W  = 24
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_a_valid,
  output logic                    o_a_ready,
  input  logic [2:0]              i_a_opcode,
  input  logic [1:0]              i_a_size,
  input  logic [SRC_W-1:0]        i_a_source,
  input  logic [ADDR_W-1:0]       i_a_address,
  input  logic [3:0]              i_a_mask,
  input  logic [31:0]             i_a_data,
  output logic                    o_d_valid,
  input  logic                    i_d_ready,
  output logic [2:0]              o_d_opcode,
  output logic [1:0]              o_d_size,
  output logic [SRC_W-1:0]        o_d_source,
  output logic [31:0]             o_d_data,
  output logic                    o_d_error,
  input  logic [NUM_CH*LED_W-1:0] i_data,
  output logic [NUM_CH*LED_W-1:0] o_data
);

  localparam int unsigned CH_W = ADDR_W - 4;

  state_e state;
  state_e state_next;

  logic [CH_W-1:0] ch;
  logic [1:0]      rsel;
  logic            accept;
  logic            is_get;
  logic            is_put;
  logic            ch_oob;
  logic            err;
  logic            wr_ok;
  logic [31:0]     rd_data;

  logic [NUM_CH-1:0]            ch_we;
  logic [NUM_CH-1:0][LED_W-1:0] out_reg;
  logic [NUM_CH-1:0][LED_W-1:0] in_reg;
  logic [NUM_CH-1:0][LED_W-1:0] led;
  logic [NUM_CH-1:0][CNT_W-1:0] period;
  logic [NUM_CH-1:0]            blink_en;

  assign ch     = i_a_address[ADDR_W-1:4];
  assign rsel   = i_a_address[3:2];
  assign is_get = (i_a_opcode == GET);
  assign is_put = (i_a_opcode == PUT_FULL) || (i_a_opcode == PUT_PARTIAL);
  assign ch_oob = (32'(ch) >= NUM_CH);
  assign err    = ch_oob
               || (i_a_address[1:0] != 2'b00)
               || (i_a_size != SIZE_WORD)
               || !(is_get || is_put)
               || ((i_a_opcode == PUT_FULL) && (i_a_mask != 4'hF))
               || (is_put && (rsel == REG_IN));
  assign accept = i_a_valid && o_a_ready;
  assign wr_ok  = accept && is_put && !err;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_a_valid) state_next = RESP;
      RESP:    if (i_d_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_a_ready = (state == IDLE);
    o_d_valid = (state == RESP);
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (32'(ch) == c) begin
        case (rsel)
          REG_OUT:  rd_data = 32'(out_reg[c]);
          REG_IN:   rd_data = 32'(in_reg[c]);
          REG_MODE: rd_data = 32'(blink_en[c]);
          default:  rd_data = 32'(period[c]);
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_d_opcode <= '0;
      o_d_size   <= '0;
      o_d_source <= '0;
      o_d_data   <= '0;
      o_d_error  <= 1'b0;
    end else if (accept) begin
      o_d_opcode <= is_get ? ACK_DATA : ACK;
      o_d_size   <= i_a_size;
      o_d_source <= i_a_source;
      o_d_data   <= (is_get && !err) ? rd_data : '0;
      o_d_error  <= err;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign ch_we[c] = wr_ok && (32'(ch) == 32'(c));

    tlul_gpio_channel #(
      .LED_W(LED_W),
      .CNT_W(CNT_W)
    ) u_ch (
      .clk      (i_clk),
      .rst      (i_reset),
      .we       (ch_we[c]),
      .wr_reg   (rsel),
      .wr_mask  (i_a_mask),
      .wr_data  (i_a_data),
      .pins     (i_data[c*LED_W +: LED_W]),
      .out_reg  (out_reg[c]),
      .in_reg   (in_reg[c]),
      .blink_en (blink_en[c]),
      .period   (period[c]),
      .led      (led[c])
    );
  end

  assign o_data = led;

endmodule

// File: doc/tlul_slave_gpio.md
# tlul_slave_gpio

Parametrised TileLink-UL slave providing NUM_CH independent LED/GPIO channels, each with a writable output register, a synchronised input register and an optional hardware blink mode. It is the multi-channel successor of the single-channel LED slave and sits on the TL-UL peripheral crossbar. It accepts one request at a time and answers on the D channel one cycle after acceptance.

## Interface
- NUM_CH, 4, number of channels (1..16)
- LED_W, 8, bits per channel (1..32)
- ADDR_W, 8, A-channel address width (at least 4 + clog2(NUM_CH))
- SRC_W, 4, source ID width
- CNT_W, 24, blink counter width
- i_clk  in  1  single clock, all logic rising-edge
- i_reset  in  1  reset, asynchronous and active-high
- i_a_valid  in  1 / o_a_ready  out  1  A-channel handshake
- i_a_opcode  in  3  request opcode: 0 PutFullData, 1 PutPartialData, 4 Get
- i_a_size  in  2  log2 bytes; only 2 is legal
- i_a_source  in  SRC_W  request ID
- i_a_address  in  ADDR_W  byte address
- i_a_mask  in  4 / i_a_data  in  32  byte lanes and write data
- o_d_valid  out  1 / i_d_ready  in  1  D-channel handshake
- o_d_opcode  out  3  response opcode: 0 AccessAck, 1 AccessAckData
- o_d_size  out  2 / o_d_source  out  SRC_W  echoed from the request
- o_d_data  out  32 / o_d_error  out  1  read data and error flag
- i_data  in  NUM_CH*LED_W  asynchronous input pins; channel c occupies [c*LED_W +: LED_W]
- o_data  out  NUM_CH*LED_W  LED outputs, same packing

## Operation
- Address map: channel = address[ADDR_W-1:4]; register = address[3:2]. Registers are zero-extended to 32 bits on read.
  - 0x0 OUT (RW, LED_W)
  - 0x4 IN (RO)
  - 0x8 MODE (RW; bit0 = blink enable)
  - 0xC PERIOD (RW, CNT_W)
- Error (o_d_error=1, no state change, o_d_data=0) on any of:
  - channel >= NUM_CH
  - address[1:0] != 0
  - size != 2
  - opcode not in {0,1,4}
  - PutFullData with mask != 4'hF
  - any write to IN
- Puts write only the enabled byte lanes; bits above the register width are ignored.
- Response opcode: Get returns AccessAckData (1), including errored Gets; Puts return AccessAck (0).
- IN is a 2-flop synchroniser of i_data. A read returns the synchronised value as of the acceptance cycle.
- Blink, per channel:
  - The counter increments every cycle while MODE.bit0=1 and PERIOD != 0.
  - When the counter equals PERIOD-1, it wraps to 0 and the phase toggles.
  - o_data = OUT & {LED_W{phase}} when blinking, otherwise OUT.
  - PERIOD=0 holds phase=1.
  - Writing PERIOD or MODE clears the counter and sets phase=1. This write wins over a simultaneous wrap.
- FSM IDLE/RESP:
  - IDLE: o_a_ready=1. On i_a_valid, the request is accepted, the write is committed at that edge, and the FSM goes to RESP.
  - RESP: o_a_ready=0 and o_d_valid=1. D fields stay stable until i_d_ready, then the FSM returns to IDLE.

## Timing
- Reset values: all registers 0, phase=1, FSM in IDLE.
  - Outputs: o_a_ready=1, o_d_valid=0, o_d_* = 0, o_data=0.
- Reset assertion mid-response drops o_d_valid immediately (asynchronously); the pending response is lost.
- Latency: o_d_valid rises in the cycle after acceptance. Back-to-back throughput is one transaction per 2 cycles.
- A written OUT value is visible on o_data in the cycle after acceptance.
- A Get of OUT issued in the cycle after a Put returns the new value.
- An i_data change is visible in IN 2 cycles later.
- Blink: with PERIOD=N, o_data toggles every N cycles (full period 2N).

## Structure
- Package tlul_pkg holds:
  - A opcodes (PUT_FULL=0, PUT_PARTIAL=1, GET=4)
  - D opcodes (ACK=0, ACK_DATA=1)
  - Register offsets (OUT=0, IN=1, MODE=2, PERIOD=3)
- Sub-module tlul_gpio_channel (OUT, MODE, PERIOD, synchroniser, blink counter, output gating) is generated NUM_CH times.
- The top level holds only the FSM, decode, error checking and the read mux.

## Test plan
- Reset, then Put 0x5A to ch1 OUT (addr 0x10, mask F) -> AccessAck with error=0, and o_data[15:8]=0x5A the next cycle; a Get of 0x10 returns 0x0000005A.
- PutPartial with mask 4'h1, data 0xFFFFFF33, to ch2 OUT (addr 0x20) after OUT=0xAA -> OUT=0x33; a mask of 4'h2 leaves OUT unchanged.
- Get of addr 0x40 (ch4, NUM_CH=4), Get of addr 0x02 and Put to 0x04 -> all give o_d_error=1 with no state change; the errored Gets return opcode 1 and data 0.
- Blink: ch0 OUT=0xFF, PERIOD=3, MODE=1 -> o_data[7:0] alternates 0xFF/0x00 every 3 cycles; a PERIOD write mid-run restarts at 0xFF.
- D backpressure: hold i_d_ready=0 for 5 cycles -> o_d_* stable, o_a_ready=0 and a second request is not accepted; assert i_reset mid-hold -> o_d_valid=0 and o_data=0 at once.
- Set i_data[7:0]=0xC3 -> a Get of addr 0x04 issued 2+ cycles later returns 0xC3.
